// File: rtl/memif_banked_if.sv
// memif_banked_if -- request/response bus of the banked memory interface.
//
// Signals:
//   req_valid, req_ready         request handshake
//   req_addr[15:0]               byte address
//   req_write                    1 = write, 0 = read
//   req_word                     1 = 16-bit big-endian access, 0 = byte
//   req_wdata[15:0]              write data (byte access uses [7:0])
//   rsp_valid, rsp_ready         response handshake
//   rsp_rdata[15:0]              read data (0 for writes)
//   rsp_err                      access rejected by the range check
//
// Modports: master = requester side, slave = memif_banked side.

interface memif_banked_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_write, req_word, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_word, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/memif_banked.sv
// memif_banked -- single-outstanding request/response front end for a
// byte-banked RAM (even bank holds even byte addresses, odd bank holds odd
// byte addresses, both with a 1-cycle registered read).
//
// Ports:
//   clk                      single clock, rising edge
//   reset                    synchronous active-high reset
//   bus                      memif_banked_if.slave request/response channel
//   read_addr_even/odd       bank read address (byte address >> 1)
//   read_data_even/odd       bank read data, valid one cycle after address
//   write_addr_even/odd      bank write address
//   write_data_even/odd      bank write data
//   write_en_even/odd        bank write strobe, high only during ISSUE
//
// Parameter:
//   ADDRBITS                 RAM is 2^ADDRBITS bytes ending at 0x3FFF
//
// Optional feature (macro MEMIF_RANGE_CHECK_EN): accesses touching bytes
// outside RAMBASE..0x3FFF do not write, and respond with rsp_err=1 and
// rsp_rdata=0 at the normal latency. Without the macro rsp_err is always 0.
//
// State  | meaning
// IDLE   | req_ready high, waiting for a request
// ISSUE  | bank addresses/data presented; write strobes high for writes
// CAPTURE| read only: bank read data valid, registered into rsp_rdata
// RESP   | rsp_valid high until the response handshake

module memif_banked #(
    parameter int ADDRBITS = 10
) (
    input  logic          clk,
    input  logic          reset,
    memif_banked_if.slave bus,
    output logic [14:0]   read_addr_even,
    input  logic [7:0]    read_data_even,
    output logic [14:0]   write_addr_even,
    output logic [7:0]    write_data_even,
    output logic          write_en_even,
    output logic [14:0]   read_addr_odd,
    input  logic [7:0]    read_data_odd,
    output logic [14:0]   write_addr_odd,
    output logic [7:0]    write_data_odd,
    output logic          write_en_odd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

`ifdef MEMIF_RANGE_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam int          RAMBASE_INT = 32'h4000 - (1 << ADDRBITS);
    localparam logic [15:0] RAMBASE     = RAMBASE_INT[15:0];
    localparam logic [15:0] RAMTOP      = 16'h3FFF;

    state_t      state;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [14:0] addr_even_q;
    logic [14:0] addr_odd_q;
    logic [7:0]  wdata_even_q;
    logic [7:0]  wdata_odd_q;
    logic        wen_even_q;
    logic        wen_odd_q;
    logic        is_write_q;
    logic        is_word_q;
    logic        lsb_q;
    logic        err_q;

    logic [15:0] addr_plus1;
    logic        lsb;
    logic        use_even;
    logic        use_odd;
    logic        out_of_range;
    logic        range_err;
    logic [15:0] capture_data;

    // The second byte of a word wraps at 16 bits (0xFFFF + 1 = 0x0000).
    assign addr_plus1 = bus.req_addr + 16'd1;
    assign lsb        = bus.req_addr[0];
    assign use_even   = bus.req_word | ~lsb;
    assign use_odd    = bus.req_word | lsb;

    // For every access the odd byte lives at A>>1 and the even byte at
    // (A+1)>>1: for even A those coincide, for odd A the even byte is the
    // low half of a word that starts one bank row earlier on the odd side.
    assign out_of_range = (bus.req_addr < RAMBASE) || (bus.req_addr > RAMTOP) ||
                          (bus.req_word && ((addr_plus1 < RAMBASE) || (addr_plus1 > RAMTOP)));
    assign range_err    = CHECK_EN & out_of_range;

    // Big-endian: high byte comes from the bank holding A.
    always_comb begin
        capture_data = 16'h0000;
        if (is_word_q) begin
            capture_data = lsb_q ? {read_data_odd, read_data_even}
                                 : {read_data_even, read_data_odd};
        end else begin
            capture_data = {8'h00, (lsb_q ? read_data_odd : read_data_even)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'h0000;
            rsp_err_q    <= 1'b0;
            addr_even_q  <= 15'd0;
            addr_odd_q   <= 15'd0;
            wdata_even_q <= 8'h00;
            wdata_odd_q  <= 8'h00;
            wen_even_q   <= 1'b0;
            wen_odd_q    <= 1'b0;
            is_write_q   <= 1'b0;
            is_word_q    <= 1'b0;
            lsb_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Strobes are one-shot: only the accept edge sets them.
            wen_even_q <= 1'b0;
            wen_odd_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q  <= 1'b0;
                        addr_even_q  <= addr_plus1[15:1];
                        addr_odd_q   <= bus.req_addr[15:1];
                        wdata_even_q <= (bus.req_word && !lsb) ? bus.req_wdata[15:8]
                                                               : bus.req_wdata[7:0];
                        wdata_odd_q  <= (bus.req_word && lsb) ? bus.req_wdata[15:8]
                                                              : bus.req_wdata[7:0];
                        wen_even_q   <= bus.req_write & use_even & ~range_err;
                        wen_odd_q    <= bus.req_write & use_odd & ~range_err;
                        is_write_q   <= bus.req_write;
                        is_word_q    <= bus.req_word;
                        lsb_q        <= lsb;
                        err_q        <= range_err;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_write_q) begin
                        rsp_rdata_q <= 16'h0000;
                        rsp_err_q   <= err_q;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_rdata_q <= err_q ? 16'h0000 : capture_data;
                    rsp_err_q   <= err_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign read_addr_even  = addr_even_q;
    assign write_addr_even = addr_even_q;
    assign write_data_even = wdata_even_q;
    assign write_en_even   = wen_even_q;
    assign read_addr_odd   = addr_odd_q;
    assign write_addr_odd  = addr_odd_q;
    assign write_data_odd  = wdata_odd_q;
    assign write_en_odd    = wen_odd_q;

endmodule
